muldiv_sequencer: RTL and testbench

- Iterative multi-cycle multiply/divide unit with its own sequencing FSM.
- Serves MULT/MULTU/DIV/DIVU for the CPU, alongside the single-cycle ALU.
- Produces 64-bit results split into HI/LO over WIDTH+2 cycles using a start/busy/done handshake.
- The pipeline stalls on busy and reads hi/lo once done is asserted.

---
 rtl/muldiv_sequencer.sv | 132 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one result bit per cycle, sign fix-up at the end,
// 64-bit result returned as hi/lo through a start/busy/done handshake.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_next;
  logic               accept;
  logic               zero_div;
  logic               signed_op;
  logic               is_div, sa, sb;
  logic [CW-1:0]      counter;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift, div_trial;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign signed_op = ~op[0];
  assign zero_div  = op[1] && (b == '0);
  assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

  // m is the multiplicand for MULT and the divisor for DIV; acc's low half holds
  // the multiplier (shifted out) or the dividend (shifted out, quotient shifted in).
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
  assign div_shift = {rem, acc[WIDTH-1]};
  assign div_trial = div_shift - {2'b00, m};
  assign div_ok    = ~div_trial[WIDTH+1];

  assign prod_fix  = (sa ^ sb) ? -acc : acc;
  assign quo_fix   = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // NOTE: every output of this block is assigned a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          accept     = 1'b1;
          state_next = zero_div ? DONE : CALC;
        end
      end
      CALC:    if (counter == '0) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div      <= 1'b0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      counter     <= '0;
      m           <= '0;
      acc         <= '0;
      rem         <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      is_div      <= op[1];
      sa          <= signed_op & a[WIDTH-1];
      sb          <= signed_op & b[WIDTH-1];
      counter     <= CW'(WIDTH - 1);
      rem         <= '0;
      div_by_zero <= 1'b0;
      if (op[1]) begin
        m   <= abs_b;
        acc <= {{WIDTH{1'b0}}, abs_a};
      end else begin
        m   <= abs_a;
        acc <= {{WIDTH{1'b0}}, abs_b};
      end
      // Divide by zero skips the datapath; the raw dividend is reported as remainder.
      if (zero_div) begin
        hi          <= a;
        lo          <= '1;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      counter <= counter - 1'b1;
      if (is_div) begin
        rem            <= div_ok ? div_trial[WIDTH:0] : div_shift[WIDTH:0];
        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ok};
      end else begin
        acc <= {mul_sum, acc[WIDTH-1:1]};
      end
    end else if (state == FIX) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        {hi, lo} <= prod_fix;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: expected results are queued at issue time
// and popped when done is observed.
module tb_muldiv_sequencer;

  localparam int W = 32;

  typedef struct packed {
    logic         dbz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic         div_by_zero;
  res_t         got;
  res_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  assign got = {div_by_zero, hi, lo};

  function automatic res_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx = $signed(x);
    longint sy = $signed(y);
    longint ux = {32'b0, x};
    longint uy = {32'b0, y};
    longint p, q, r;
    res_t   res;
    res = '0;
    case (o)
      2'b00: begin p = sx * sy; res = {1'b0, p[63:32], p[31:0]}; end
      2'b01: begin p = ux * uy; res = {1'b0, p[63:32], p[31:0]}; end
      default: begin
        if (y == '0) begin
          res = {1'b1, x, {W{1'b1}}};
        end else begin
          if (o == 2'b10) begin q = sx / sy; r = sx % sy; end
          else            begin q = ux / uy; r = ux % uy; end
          res = {1'b0, r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Drives one start at a negedge; returns at the negedge of cycle 1 with inputs scrambled.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input int n0, output int n, output bit busy_ok);
    n = n0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (done === 1'b1 && busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, got} !== {2'b00, 65'b0}) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h expected all zero", busy, done, got);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_multu;
    int n; bit bok; res_t e;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (n !== 34) begin errors++; $display("FAIL multu_latency: got %0d expected 34", n); end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL multu_busy: busy not high for cycles 1-33 / low at done"); end
    checks++;
    if (got !== e || e !== {1'b0, 32'hFFFF_FFFE, 32'h0000_0001}) begin
      errors++; $display("FAIL multu_result: got %h expected %h", got, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_mult;
    int n; bit bok; res_t e;
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (got !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
      errors++; $display("FAIL mult_neg: got %h expected %h", got, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    end
    @(negedge clk);
    issue(2'b00, 32'd0, 32'h8000_0000);
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL mult_zero: got %h expected %h", got, e); end
    @(negedge clk);
  endtask

  task automatic test_div;
    int n; bit bok; res_t e;
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (got !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL div_neg: got %h expected %h", got, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    @(negedge clk);
    issue(2'b11, 32'd100, 32'd7);
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (got !== {1'b0, 32'd2, 32'd14}) begin
      errors++; $display("FAIL divu: got %h expected %h", got, {1'b0, 32'd2, 32'd14});
    end
    @(negedge clk);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (got !== {1'b0, 32'd0, 32'h8000_0000} || n !== 34) begin
      errors++; $display("FAIL div_minneg: got %h at cycle %0d expected %h at 34", got, n, {1'b0, 32'd0, 32'h8000_0000});
    end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero;
    int n; bit bok; res_t e;
    issue(2'b11, 32'd5, 32'd0);
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (n !== 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", n); end
    checks++;
    if (got !== {1'b1, 32'd5, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL dbz_result: got %h expected %h", got, {1'b1, 32'd5, 32'hFFFF_FFFF});
    end
    @(negedge clk);
    checks++;
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_hold: got %b expected 1", div_by_zero); end
    issue(2'b01, 32'd2, 32'd3);
    checks++;
    if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b expected 0", div_by_zero); end
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL dbz_next: got %h expected %h", got, e); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int n; int extra; bit bok; res_t e;
    issue(2'b01, 32'd12345, 32'd678);
    repeat (3) @(negedge clk);
    op = 2'b10; a = 32'd99; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (n !== 34 || got !== e) begin
      errors++; $display("FAIL ignore_start: got %h at cycle %0d expected %h at 34", got, n, e);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL ignore_not_queued: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back;
    int n; bit bok; res_t e;
    issue(2'b01, 32'd1000, 32'd2000);
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL b2b_first: got %h expected %h", got, e); end
    issue(2'b11, 32'd1000000, 32'd333);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap: got busy=%b expected 1", busy); end
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (n !== 34 || got !== e) begin
      errors++; $display("FAIL b2b_second: got %h at cycle %0d expected %h at 34", got, n, e);
    end
  endtask

  task automatic test_reset_abort;
    int n; int seen; bit bok; res_t e;
    issue(2'b01, 32'd77, 32'd88);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({busy, done, got} !== {2'b00, 65'b0}) begin
      errors++; $display("FAIL abort_clear: got busy=%b done=%b res=%h expected all zero", busy, done, got);
    end
    seen = 0;
    repeat (2) begin @(negedge clk); if (done === 1'b1) seen++; end
    reset = 1'b0;
    repeat (40) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
    issue(2'b01, 32'd6, 32'd7);
    wait_done(1, n, bok);
    e = exp_q.pop_front();
    checks++;
    if (got !== {1'b0, 32'd0, 32'd42}) begin
      errors++; $display("FAIL abort_recover: got %h expected %h", got, {1'b0, 32'd0, 32'd42});
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int n; bit bok; res_t e;
    logic [W-1:0] corner [6];
    logic [W-1:0] x, y;
    logic [1:0]   o;
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'd3;
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom);
      x = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      issue(o, x, y);
      wait_done(1, n, bok);
      e = exp_q.pop_front();
      checks++;
      if (got !== e || n !== (e.dbz ? 1 : 34)) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h at cycle %0d expected %h", i, o, x, y, got, n, e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    start = 1'b0; op = 2'b00; a = '0; b = '0; reset = 1'b1;
    @(negedge clk);
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_div_by_zero;
    test_ignore_start;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
